pipeline_hazard_controller: RTL
===============================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-high reset.
REQ-002 SHALL have ports: rs1_address_id_i, rs2_address_id_i, rs3_address_id_i  in  5 each  source registers of the instruction in ID.
REQ-003 SHALL have ports: rs3_used_id_i  in  1  ID instruction reads rs3; branch_id_i  in  1  ID holds a branch; branch_taken_id_i  in  1  branch resolved taken in ID.
REQ-004 SHALL have ports: rd_we_ex_i  in  1  EX writes rd; mem_to_reg_ex_i  in  1  EX holds a load; rd_address_ex_i  in  5  EX destination.
REQ-005 SHALL have ports: mdu_start_ex_i  in  1  multi-cycle mul/div issued in EX; mdu_done_i  in  1  MDU result valid, 1-cycle pulse.
REQ-006 SHALL have ports: pc_en_o, if_id_en_o, id_ex_en_o  out  1 each  stage-register enables; if_id_flush_o, id_ex_flush_o  out  1 each  bubble insert.
REQ-007 SHALL have ports: mdu_busy_o  out  1  in MDU_WAIT; mdu_timeout_o  out  1  sticky timeout error flag.

Function
REQ-008 SHALL implement states RUN, BR_LOAD_STALL, MDU_WAIT; RUN is the reset state.
REQ-009 SHALL define hit(x) = x != 0 and x equals rs1_address_id_i or rs2_address_id_i, or rs3_address_id_i when rs3_used_id_i.
REQ-010 Load-use (RUN): mem_to_reg_ex_i && hit(rd_address_ex_i) SHALL, in the same cycle, drive pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1; one stall cycle.
REQ-011 Branch-ALU (RUN): branch_id_i && rd_we_ex_i && !mem_to_reg_ex_i && rd_address_ex_i nonzero matching rs1/rs2 SHALL stall one cycle as REQ-010.
REQ-012 Branch-load (RUN): branch_id_i && mem_to_reg_ex_i && rd_address_ex_i nonzero matching rs1/rs2 SHALL stall as REQ-010 and go to BR_LOAD_STALL.
REQ-013 BR_LOAD_STALL SHALL unconditionally stall one more cycle (same outputs as REQ-010) then return to RUN; total 2 stall cycles.
REQ-014 RUN with mdu_start_ex_i SHALL go to MDU_WAIT next cycle and clear the timeout counter; pipeline is not stalled in the issue cycle.
REQ-015 MDU_WAIT SHALL drive pc_en_o=0, if_id_en_o=0, id_ex_en_o=0, flushes 0, mdu_busy_o=1.
REQ-016 MDU_WAIT with mdu_done_i SHALL release all enables in that same cycle and return to RUN.
REQ-017 6-bit counter SHALL increment each MDU_WAIT cycle; at MDU_TIMEOUT=40 without done SHALL set mdu_timeout_o and return to RUN.
REQ-018 Priority SHALL be MDU_WAIT > BR_LOAD_STALL > load-use/branch hazards > flush.
REQ-019 if_id_flush_o SHALL equal branch_taken_id_i only in RUN with no stall; suppressed otherwise.
REQ-020 No hazard, RUN: all enables 1, flushes 0.
REQ-021 x0 destination SHALL never cause a stall.

Reset
REQ-022 rst SHALL asynchronously force state RUN, counter 0, mdu_timeout_o 0.
REQ-023 While rst=1: pc_en_o, if_id_en_o, id_ex_en_o=0; if_id_flush_o, id_ex_flush_o=1; mdu_busy_o=0.
REQ-024 rst mid-MDU_WAIT or mid-BR_LOAD_STALL SHALL abandon the sequence; first post-reset cycle is RUN.
REQ-025 mdu_timeout_o SHALL be cleared only by rst.

Structure
REQ-026 hazard_ctrl_pkg SHALL hold the state enum, MDU_TIMEOUT=40, and counter width.
REQ-027 Comparators SHALL live in one combinational sub-module hazard_detect producing load_use, br_alu, br_load; FSM, counter and output decode in the top.

Verification
REQ-028 EX lw x5, ID add x6,x5,x1 -> one cycle pc_en_o=0, id_ex_flush_o=1, then RUN with enables 1.
REQ-029 EX lw x7, ID beq x7,x2 -> exactly 2 stall cycles, then branch_taken_id_i=1 yields if_id_flush_o=1 for one cycle.
REQ-030 mdu_start_ex_i=1, mdu_done_i after 33 cycles -> mdu_busy_o=1 for 33 cycles, enables return 1 in the done cycle.
REQ-031 mdu_start_ex_i with no done -> mdu_timeout_o=1 after 40 cycles, state RUN, flag stays 1 until rst.
REQ-032 EX lw x0 with ID rs1=0, and rs3 match with rs3_used_id_i=0 -> no stall.
REQ-033 rst pulse during MDU_WAIT cycle 10 -> outputs per REQ-023 immediately; after release enables 1, mdu_busy_o=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding and MDU wait bounds.
package hazard_ctrl_pkg;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] MDU_TIMEOUT = 6'd40;

  typedef enum logic [1:0] {
    RUN           = 2'd0,
    BR_LOAD_STALL = 2'd1,
    MDU_WAIT      = 2'd2
  } hz_state_t;

  function automatic logic rd_hit2(
    input logic [4:0] rd,
    input logic [4:0] a,
    input logic [4:0] b
  );
    return (rd != 5'd0) && ((rd == a) || (rd == b));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Register-match comparators between the EX destination and ID sources.
// Purely combinational; sequencing lives in the top.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rs3,
  input  logic       rs3_used,
  input  logic       branch,
  input  logic       rd_we,
  input  logic       mem_to_reg,
  input  logic [4:0] rd,
  output logic       load_use,
  output logic       br_alu,
  output logic       br_load
);

  logic hit12;
  logic hit3;

  assign hit12 = rd_hit2(rd, rs1, rs2);
  assign hit3  = rs3_used && (rd != 5'd0) && (rd == rs3);

  assign load_use = mem_to_reg && (hit12 || hit3);
  // Branches resolve in ID, so even ALU results must be waited for
  assign br_alu   = branch && rd_we && !mem_to_reg && hit12;
  assign br_load  = branch && mem_to_reg && hit12;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller: load-use, branch-in-ID hazards and MDU waits.
// FSM, timeout counter and output decode.
module pipeline_hazard_controller
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_address_id_i,
  input  logic [4:0] rs2_address_id_i,
  input  logic [4:0] rs3_address_id_i,
  input  logic       rs3_used_id_i,
  input  logic       branch_id_i,
  input  logic       branch_taken_id_i,
  input  logic       rd_we_ex_i,
  input  logic       mem_to_reg_ex_i,
  input  logic [4:0] rd_address_ex_i,
  input  logic       mdu_start_ex_i,
  input  logic       mdu_done_i,
  output logic       pc_en_o,
  output logic       if_id_en_o,
  output logic       id_ex_en_o,
  output logic       if_id_flush_o,
  output logic       id_ex_flush_o,
  output logic       mdu_busy_o,
  output logic       mdu_timeout_o
);

  hz_state_t        state_q;
  hz_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             tmo_q;
  logic             tmo_d;

  logic load_use;
  logic br_alu;
  logic br_load;
  logic stall;

  hazard_detect u_detect (
    .rs1        (rs1_address_id_i),
    .rs2        (rs2_address_id_i),
    .rs3        (rs3_address_id_i),
    .rs3_used   (rs3_used_id_i),
    .branch     (branch_id_i),
    .rd_we      (rd_we_ex_i),
    .mem_to_reg (mem_to_reg_ex_i),
    .rd         (rd_address_ex_i),
    .load_use   (load_use),
    .br_alu     (br_alu),
    .br_load    (br_load)
  );

  assign stall   = load_use || br_alu || br_load;
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    pc_en_o       = 1'b1;
    if_id_en_o    = 1'b1;
    id_ex_en_o    = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    mdu_busy_o    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (stall) begin
          pc_en_o       = 1'b0;
          if_id_en_o    = 1'b0;
          id_ex_flush_o = 1'b1;
        end else begin
          if_id_flush_o = branch_taken_id_i;
        end
        if (mdu_start_ex_i) begin
          state_d = MDU_WAIT;
          cnt_d   = '0;
        end else if (br_load) begin
          state_d = BR_LOAD_STALL;
        end
      end
      BR_LOAD_STALL: begin
        pc_en_o       = 1'b0;
        if_id_en_o    = 1'b0;
        id_ex_flush_o = 1'b1;
        state_d       = RUN;
      end
      MDU_WAIT: begin
        mdu_busy_o = 1'b1;
        if (mdu_done_i) begin
          state_d = RUN;
        end else begin
          pc_en_o    = 1'b0;
          if_id_en_o = 1'b0;
          id_ex_en_o = 1'b0;
          cnt_d      = cnt_inc;
          // Give up on a hung MDU rather than freezing the core
          if (cnt_inc == MDU_TIMEOUT) begin
            tmo_d   = 1'b1;
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase

    if (rst) begin
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_en_o    = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      mdu_busy_o    = 1'b0;
    end
  end

  assign mdu_timeout_o = tmo_q;

endmodule
